mult_op_dispatcher: RTL and testbench
=====================================

// Module: mult_op_dispatcher
// PURPOSE
//  Upstream sequencer for the floating-point multiplier core. Accepts operand pairs on a valid/ready interface, holds them stable,
//  drives the core's beg_FSM/rst_FSM handshake, captures the product on core ready and presents it downstream on valid/ready.
//  Adds a watchdog that force-resets a hung core and flags the error.
// PARAMETERS
//  W         32    operand/result width (IEEE-754 single by default; 64 for double)
//  TIMEOUT   255   max cycles in S_WAIT before watchdog fires (1..2^CNT_W-1)
//  CNT_W     8     watchdog counter width
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-low reset
//  in_valid      in   1  operand pair valid
//  in_ready      out  1  dispatcher accepts operands this cycle
//  in_op_a       in   W  operand A
//  in_op_b       in   W  operand B
//  core_op_a     out  W  operand A to core, held stable from launch to ack
//  core_op_b     out  W  operand B to core
//  core_beg      out  1  to core beg_FSM; one-cycle pulse
//  core_ack      out  1  to core rst_FSM; one-cycle pulse
//  core_rst      out  1  active-high reset to core; registered
//  core_ready    in   1  core ready (high only in its final state)
//  core_result   in   W  core product, valid while core_ready=1
//  out_valid     out  1  result valid
//  out_ready     in   1  downstream accepts result
//  out_result    out  W  product
//  timeout_err   out  1  sticky: watchdog fired since last reset
// BEHAVIOUR
//  Reset (rst=0): state=S_IDLE; in_ready=0; core_beg=core_ack=0; core_rst=1; core_op_a/b=0; out_valid=0; out_result=0;
//   timeout_err=0; watchdog=0. core_rst deasserts on first clk edge after rst releases.
//  States:
//   S_IDLE   : in_ready=1 (only when core_rst=0). On in_valid&in_ready latch operands into core_op_a/b -> S_LAUNCH.
//   S_LAUNCH : core_beg=1 for exactly this cycle -> S_WAIT; watchdog cleared.
//   S_WAIT   : watchdog increments each cycle. If core_ready=1 and out_valid=0: load out_result<=core_result, out_valid<=1 -> S_ACK.
//              If core_ready=1 and out_valid=1 (previous result unconsumed): stay, do not ack, watchdog frozen (backpressure, not hang).
//              If watchdog==TIMEOUT and core_ready=0: core_rst=1 for one cycle, timeout_err<=1 -> S_IDLE; no result produced.
//   S_ACK    : core_ack=1 for exactly this cycle -> S_DRAIN.
//   S_DRAIN  : one settle cycle for core to leave its final state (core_ready must be 0 here) -> S_IDLE.
//  Output register: out_valid clears on out_valid&out_ready; a capture in the same cycle as a drain is allowed (new value loads,
//   out_valid stays 1). out_result stable while out_valid=1&out_ready=0.
//  in_ready is 0 in every state except S_IDLE; so the next launch may overlap a pending output, but capture waits for space.
//  Latency: accept edge -> core_beg next cycle; core_ready -> out_valid one cycle later (when output empty).
//   Min back-to-back issue interval = core latency + 4 cycles.
//  core_op_a/b change only on accept in S_IDLE.
//  core_result sampled only in S_WAIT with core_ready=1; core_ready in any other state is ignored.
//  Watchdog saturates at TIMEOUT; it never wraps.
//  timeout_err cleared only by rst.
//  Reset mid-operation: all state lost, core_rst asserted, any held result discarded.
//  All outputs registered except in_ready, which is decoded from state and core_rst.
// TESTING
//  1. W=32: push A=32'h3FC00000, B=32'h40000000 with core model -> core_beg 1 cycle after accept, out_result=32'h40400000, one core_ack pulse.
//  2. out_ready held 0 across two ops -> 2nd op holds in S_WAIT, no core_ack; release out_ready -> results 1st then 2nd, in order.
//  3. Core model never raises core_ready, TIMEOUT=16 -> core_rst pulse at 17th S_WAIT cycle, timeout_err=1, no out_valid, in_ready back to 1.
//  4. in_valid asserted during S_WAIT/S_ACK -> in_ready=0, operands not latched, core_op_a/b unchanged.
//  5. rst pulled low during S_WAIT -> all outputs at reset values, core_rst=1; after release a new op completes normally.
//  6. out_ready=1 same cycle as a new capture -> out_valid stays 1, out_result updates, no result lost or duplicated.

Source files
------------

// File: rtl/mult_op_dispatcher.sv
// Sequencer between a valid/ready operand stream and the floating-point multiplier core.
// Drives the core's start/acknowledge handshake, buffers one product and resets a hung core.
module mult_op_dispatcher #(
  parameter int W       = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_op_a,
  input  logic [W-1:0] in_op_b,
  output logic [W-1:0] core_op_a,
  output logic [W-1:0] core_op_b,
  output logic         core_beg,
  output logic         core_ack,
  output logic         core_rst,
  input  logic         core_ready,
  input  logic [W-1:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ACK    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  state_t         state_r, state_nxt_s;
  logic [CNT_W-1:0] wd_r, wd_nxt_s;
  logic [W-1:0]   op_a_r, op_a_nxt_s, op_b_r, op_b_nxt_s;
  logic [W-1:0]   res_r, res_nxt_s;
  logic           out_valid_r, out_valid_nxt_s;
  logic           beg_r, beg_nxt_s, ack_r, ack_nxt_s;
  logic           core_rst_r, core_rst_nxt_s;
  logic           terr_r, terr_nxt_s;
  logic           accept_s, space_s, capture_s, stall_s, fire_s;

  assign in_ready  = (state_r == S_IDLE) && !core_rst_r;
  assign accept_s  = in_valid && in_ready;
  // A slot frees up either when empty or when the held result leaves this cycle.
  assign space_s   = !out_valid_r || out_ready;
  assign capture_s = (state_r == S_WAIT) && core_ready && space_s;
  assign stall_s   = (state_r == S_WAIT) && core_ready && !space_s;
  assign fire_s    = (state_r == S_WAIT) && !core_ready && (wd_r == TMO_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   if (accept_s) state_nxt_s = S_LAUNCH; else state_nxt_s = S_IDLE;
      S_LAUNCH: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (capture_s)   state_nxt_s = S_ACK;
        else if (fire_s) state_nxt_s = S_IDLE;
        else             state_nxt_s = S_WAIT;
      end
      S_ACK:    state_nxt_s = S_DRAIN;
      S_DRAIN:  state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Next values for every registered output and the watchdog
  always_comb begin
    op_a_nxt_s      = op_a_r;
    op_b_nxt_s      = op_b_r;
    wd_nxt_s        = wd_r;
    res_nxt_s       = res_r;
    out_valid_nxt_s = out_valid_r;
    beg_nxt_s       = (state_nxt_s == S_LAUNCH);
    ack_nxt_s       = (state_nxt_s == S_ACK);
    core_rst_nxt_s  = fire_s;
    terr_nxt_s      = terr_r || fire_s;
    if (accept_s) begin
      op_a_nxt_s = in_op_a;
      op_b_nxt_s = in_op_b;
    end else begin
      op_a_nxt_s = op_a_r;
      op_b_nxt_s = op_b_r;
    end
    // Watchdog freezes while the core waits on downstream backpressure.
    if (state_r == S_LAUNCH) begin
      wd_nxt_s = {CNT_W{1'b0}};
    end else if ((state_r == S_WAIT) && !stall_s && (wd_r != TMO_LIMIT)) begin
      wd_nxt_s = wd_r + CNT_W'(1);
    end else begin
      wd_nxt_s = wd_r;
    end
    if (capture_s) begin
      res_nxt_s       = core_result;
      out_valid_nxt_s = 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_r      <= {W{1'b0}};
      op_b_r      <= {W{1'b0}};
      wd_r        <= {CNT_W{1'b0}};
      res_r       <= {W{1'b0}};
      out_valid_r <= 1'b0;
      beg_r       <= 1'b0;
      ack_r       <= 1'b0;
      core_rst_r  <= 1'b1;
      terr_r      <= 1'b0;
    end else begin
      op_a_r      <= op_a_nxt_s;
      op_b_r      <= op_b_nxt_s;
      wd_r        <= wd_nxt_s;
      res_r       <= res_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      beg_r       <= beg_nxt_s;
      ack_r       <= ack_nxt_s;
      core_rst_r  <= core_rst_nxt_s;
      terr_r      <= terr_nxt_s;
    end
  end

  assign core_op_a   = op_a_r;
  assign core_op_b   = op_b_r;
  assign core_beg    = beg_r;
  assign core_ack    = ack_r;
  assign core_rst    = core_rst_r;
  assign out_valid   = out_valid_r;
  assign out_result  = res_r;
  assign timeout_err = terr_r;

endmodule

// File: tb/tb_mult_op_dispatcher.sv
// Directed bench for mult_op_dispatcher with a small behavioural multiplier core model.
module tb_mult_op_dispatcher;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_op_a = 32'h0, in_op_b = 32'h0;
  logic [W-1:0] core_op_a, core_op_b, core_result, out_result;
  logic         core_beg, core_ack, core_rst, core_ready;
  logic         out_valid, out_ready = 1'b0, timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int a0;
  int n;

  logic         hang = 1'b0;
  logic         m_rdy = 1'b0, m_busy = 1'b0;
  logic [3:0]   m_cnt = 4'd0;
  logic [W-1:0] m_res = 32'h0;

  always #5 clk = ~clk;

  mult_op_dispatcher #(.W(W), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .core_op_a(core_op_a), .core_op_b(core_op_b), .core_beg(core_beg), .core_ack(core_ack),
    .core_rst(core_rst), .core_ready(core_ready), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .timeout_err(timeout_err)
  );

  // Hand-computed single-precision products for the operand pairs used here.
  function automatic logic [31:0] fp_mul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FC00000_40000000: return 32'h40400000;
      64'h40000000_40400000: return 32'h40C00000;
      64'h3F800000_40A00000: return 32'h40A00000;
      64'h40800000_3F000000: return 32'h40000000;
      default:               return 32'hFFFFFFFF;
    endcase
  endfunction

  assign core_ready  = m_rdy;
  assign core_result = m_res;

  // Core model: ready LAT+1 cycles after beg, held until ack; hangs when asked to.
  always @(posedge clk) begin
    if (core_rst) begin
      m_rdy <= 1'b0; m_busy <= 1'b0; m_cnt <= 4'd0; m_res <= 32'h0;
    end else if (core_ack) begin
      m_rdy <= 1'b0;
    end else if (core_beg && !hang) begin
      m_busy <= 1'b1; m_cnt <= 4'(LAT);
    end else if (m_busy) begin
      if (m_cnt == 4'd0) begin
        m_busy <= 1'b0; m_rdy <= 1'b1; m_res <= fp_mul_ref(core_op_a, core_op_b);
      end else begin
        m_cnt <= m_cnt - 4'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (core_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    check("issue_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op_a = a; in_op_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    check("beg_after_accept", {31'b0, core_beg}, 32'd1);
    check("op_a_latched", core_op_a, a);
    check("op_b_latched", core_op_b, b);
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    check(tag, out_result, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_core_rst", {31'b0, core_rst}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_core_beg", {31'b0, core_beg}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst_core_op_a", core_op_a, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_core_rst", {31'b0, core_rst}, 32'd0);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic product: 1.5 * 2.0 = 3.0
    a0 = ack_cnt;
    issue(32'h3FC00000, 32'h40000000);
    @(negedge clk);
    check("beg_one_cycle", {31'b0, core_beg}, 32'd0);
    wait_out("t1_res", 32'h40400000);
    repeat (3) @(negedge clk);
    check("t1_ack_count", ack_cnt - a0, 32'd1);

    // Backpressure across two ops, then same-cycle drain and capture
    a0 = ack_cnt;
    issue(32'h40000000, 32'h40400000);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    issue(32'h3F800000, 32'h40A00000);
    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_op_a = 32'h40800000; in_op_b = 32'h3F000000;
    repeat (3) @(negedge clk);
    check("busy_in_ready", {31'b0, in_ready}, 32'd0);
    check("busy_op_a_held", core_op_a, 32'h3F800000);
    check("busy_op_b_held", core_op_b, 32'h40A00000);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("bp_ack_count", ack_cnt - a0, 32'd1);
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    check("bp_first_result", out_result, 32'h40C00000);
    check("bp_no_timeout", {31'b0, timeout_err}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("swap_out_valid", {31'b0, out_valid}, 32'd1);
    check("swap_second_result", out_result, 32'h40A00000);
    @(negedge clk);
    out_ready = 1'b0;
    check("swap_drained", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp_ack_count_final", ack_cnt - a0, 32'd2);

    // Hung core: watchdog fires after the 17th wait cycle
    hang = 1'b1;
    a0 = ack_cnt;
    issue(32'h40800000, 32'h3F000000);
    n = 0;
    while (!core_rst && n < 40) begin @(negedge clk); n++; end
    check("wd_cycles", n, 32'd18);
    check("wd_timeout_err", {31'b0, timeout_err}, 32'd1);
    check("wd_no_out_valid", {31'b0, out_valid}, 32'd0);
    check("wd_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("wd_core_rst_pulse", {31'b0, core_rst}, 32'd0);
    check("wd_in_ready_back", {31'b0, in_ready}, 32'd1);
    check("wd_no_ack", ack_cnt - a0, 32'd0);
    hang = 1'b0;

    // Reset mid-operation, then a clean op
    issue(32'h40800000, 32'h3F000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_core_rst", {31'b0, core_rst}, 32'd1);
    check("mid_rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_core_op_a", core_op_a, 32'h0);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(32'h40800000, 32'h3F000000);
    wait_out("t5_res", 32'h40000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
